// File: rtl/cla_div_pkg.sv
// Shared types and constants for the 8-bit restoring divider and its CLA adder.
package cla_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int              WIDTH     = 8;
    localparam int              STEPS     = 8;
    localparam int              CNT_W     = 3;
    localparam logic [CNT_W-1:0] LAST_STEP = 3'd7;
    localparam logic [WIDTH-1:0] DIV0_QUOT = 8'hFF;

endpackage

// File: rtl/cla_adder_8.sv
// 8-bit carry-lookahead adder: every carry is a flat sum-of-products of the
// generate/propagate terms and carry_in, so no carry ripples through a sum bit.
module cla_adder_8
    import cla_div_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic term;
        c    = '0;
        term = 1'b0;
        c[0] = carry_in;
        for (int i = 0; i < WIDTH; i++) begin
            // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]carry_in
            for (int j = 0; j <= i + 1; j++) begin
                term = (j == 0) ? carry_in : g[j-1];
                for (int k = j; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
    end

    assign sum       = p ^ c[WIDTH-1:0];
    assign carry_out = c[WIDTH];

endmodule

// File: rtl/cla_restoring_divider_8.sv
// Multi-cycle 8-bit unsigned restoring divider: one quotient bit per CALC cycle,
// trial subtraction through the CLA adder, valid/ready handshakes on both sides.
module cla_restoring_divider_8
    import cla_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    // Partial remainder is always < divisor between steps, so its 9th bit only
    // exists transiently in the shifted value below.
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] trial;
    logic             trial_cout;
    logic             sub_ok;

    assign r_shift = {r_q, q_q[WIDTH-1]};

    cla_adder_8 u_sub (
        .a         (r_shift[WIDTH-1:0]),
        .b         (~d_q),
        .carry_in  (1'b1),
        .sum       (trial),
        .carry_out (trial_cout)
    );

    assign sub_ok = r_shift[WIDTH] | trial_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        d_d       = d_q;
        r_d       = r_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    d_d   = divisor;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        q_d     = DIV0_QUOT;
                        r_d     = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = sub_ok ? trial : r_shift[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], sub_ok};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule
